store_buffer: RTL and testbench

Posted-write buffer between the core's data port (`MemWrite`/`DataAdr`/`WriteData`/`ReadData`) and a backing data memory that accepts writes through a valid/ready handshake. Core stores are queued in a FIFO and drained in order. Core loads read combinationally, with data forwarded from the youngest matching queued store. A `stall` output lets the core hold its PC when the queue cannot accept a store.

---
 rtl/store_buffer_if.sv | 32 +++
 rtl/store_buffer.sv | 96 +++++++++
 tb/tb_store_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Core data-port and backing-memory write-port signals of the store buffer.
// The slave modport is the buffer's view; master is the surrounding core/memory.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          we;
    logic [31:0]   a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          stall;
    logic [31:0]   mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [CW-1:0] count;
    logic          empty;

    modport slave (
        input  we, a, wd, mem_rdata, mem_ready,
        output rd, stall, mem_raddr, mem_valid, mem_waddr, mem_wdata, count, empty
    );

    modport master (
        output we, a, wd, mem_rdata, mem_ready,
        input  rd, stall, mem_raddr, mem_valid, mem_waddr, mem_wdata, count, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and backing memory, with
// youngest-match load forwarding from stores still waiting to drain.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  sb_if
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          enq;
    logic          deq;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign full            = (count_q == CW'(DEPTH));
    assign sb_if.mem_valid = (count_q != '0);
    assign sb_if.empty     = (count_q == '0);
    assign sb_if.count     = count_q;

    // A draining head frees a slot this same cycle, so a full queue only
    // pushes back when the memory is not taking the head.
    assign sb_if.stall = sb_if.we & full & ~sb_if.mem_ready;
    assign enq         = sb_if.we & ~sb_if.stall;
    assign deq         = sb_if.mem_valid & sb_if.mem_ready;

    // Head fields are masked so the bus reads zero while nothing is queued.
    assign sb_if.mem_waddr = sb_if.mem_valid ? {addr_q[head_q], 2'b00} : 32'd0;
    assign sb_if.mem_wdata = sb_if.mem_valid ? data_q[head_q] : '0;
    assign sb_if.mem_raddr = {sb_if.a[31:2], 2'b00};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) head_d = head_q + PW'(1);
        if (enq) tail_d = tail_q + PW'(1);
        if (enq && !deq)      count_d = count_q + CW'(1);
        else if (deq && !enq) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: slots outside [head, head+count) are never read.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= sb_if.a[31:2];
            data_q[tail_q] <= sb_if.wd;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx] == sb_if.a[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign sb_if.rd = fwd_hit ? fwd_data : sb_if.mem_rdata;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        count_q <= CW'(DEPTH));

    a_head_hold: assert property (@(posedge clk) disable iff (reset)
        (sb_if.mem_valid && !sb_if.mem_ready) |=>
            ($stable(sb_if.mem_waddr) && $stable(sb_if.mem_wdata)));

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .DW(DW)) sb_if ();

    store_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .sb_if (sb_if.slave)
    );

    logic [31:0] rdata_fix;
    logic        rd_fn;
    function automatic logic [31:0] mem_fn(input logic [31:0] ad);
        return ad ^ 32'h5A5A_0000;
    endfunction
    assign sb_if.mem_rdata = rd_fn ? mem_fn(sb_if.mem_raddr) : rdata_fix;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t dut_log[$];

    always @(posedge clk)
        if (!reset && sb_if.mem_valid && sb_if.mem_ready)
            dut_log.push_back('{sb_if.mem_waddr, sb_if.mem_wdata});

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step(input logic we_v, input logic [31:0] a_v, input logic [31:0] wd_v,
                        input logic rdy_v);
        @(posedge clk);
        #1;
        sb_if.we        = we_v;
        sb_if.a         = a_v;
        sb_if.wd        = wd_v;
        sb_if.mem_ready = rdy_v;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic        e_stall;
        logic [31:0] e_rd;
        int          e_cnt;
        logic        e_valid;
        logic [31:0] e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                input logic rdy, input logic st, input logic [31:0] r,
                                input int c, input logic v, input logic [31:0] wa,
                                input logic [31:0] wdt);
        vec_t t;
        t = '{we, a, wd, rdy, st, r, c, v, wa, wdt};
        return t;
    endfunction

    vec_t tbl[23];
    wr_t  mq[$];
    wr_t  mlog[$];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors; mem_rdata fixed at DEAD throughout the table.
        tbl[0]  = mk(1, 32'h40, 32'h11, 0, 0, 32'hDEAD, 0, 0, 32'h0,  32'h0);
        tbl[1]  = mk(0, 32'h40, 32'h0,  0, 0, 32'h11,   1, 1, 32'h40, 32'h11);
        tbl[2]  = mk(0, 32'h0,  32'h0,  1, 0, 32'hDEAD, 1, 1, 32'h40, 32'h11);
        tbl[3]  = mk(1, 32'h40, 32'h5,  0, 0, 32'hDEAD, 0, 0, 32'h0,  32'h0);
        tbl[4]  = mk(1, 32'h40, 32'h9,  0, 0, 32'h5,    1, 1, 32'h40, 32'h5);
        tbl[5]  = mk(0, 32'h40, 32'h0,  0, 0, 32'h9,    2, 1, 32'h40, 32'h5);
        tbl[6]  = mk(0, 32'h44, 32'h0,  0, 0, 32'hDEAD, 2, 1, 32'h40, 32'h5);
        tbl[7]  = mk(0, 32'h42, 32'h0,  0, 0, 32'h9,    2, 1, 32'h40, 32'h5);
        tbl[8]  = mk(0, 32'h40, 32'h0,  1, 0, 32'h9,    2, 1, 32'h40, 32'h5);
        tbl[9]  = mk(0, 32'h40, 32'h0,  1, 0, 32'h9,    1, 1, 32'h40, 32'h9);
        tbl[10] = mk(1, 32'h0,  32'hA0, 0, 0, 32'hDEAD, 0, 0, 32'h0,  32'h0);
        tbl[11] = mk(1, 32'h4,  32'hA1, 0, 0, 32'hDEAD, 1, 1, 32'h0,  32'hA0);
        tbl[12] = mk(1, 32'h8,  32'hA2, 0, 0, 32'hDEAD, 2, 1, 32'h0,  32'hA0);
        tbl[13] = mk(1, 32'hC,  32'hA3, 0, 0, 32'hDEAD, 3, 1, 32'h0,  32'hA0);
        tbl[14] = mk(1, 32'h10, 32'hA4, 0, 1, 32'hDEAD, 4, 1, 32'h0,  32'hA0);
        tbl[15] = mk(1, 32'h10, 32'hA4, 0, 1, 32'hDEAD, 4, 1, 32'h0,  32'hA0);
        tbl[16] = mk(1, 32'h10, 32'hA4, 1, 0, 32'hDEAD, 4, 1, 32'h0,  32'hA0);
        tbl[17] = mk(0, 32'h10, 32'h0,  0, 0, 32'hA4,   4, 1, 32'h4,  32'hA1);
        tbl[18] = mk(0, 32'h0,  32'h0,  1, 0, 32'hDEAD, 4, 1, 32'h4,  32'hA1);
        tbl[19] = mk(0, 32'h0,  32'h0,  1, 0, 32'hDEAD, 3, 1, 32'h8,  32'hA2);
        tbl[20] = mk(0, 32'h0,  32'h0,  1, 0, 32'hDEAD, 2, 1, 32'hC,  32'hA3);
        tbl[21] = mk(0, 32'h0,  32'h0,  1, 0, 32'hDEAD, 1, 1, 32'h10, 32'hA4);
        tbl[22] = mk(0, 32'h0,  32'h0,  0, 0, 32'hDEAD, 0, 0, 32'h0,  32'h0);

        reset = 1'b1;
        sb_if.we = 1'b0; sb_if.a = '0; sb_if.wd = '0; sb_if.mem_ready = 1'b0;
        rd_fn = 1'b0; rdata_fix = 32'hDEAD;
        #3;
        chk("rst_count", 32'(sb_if.count), 32'd0);
        chk("rst_empty", 32'(sb_if.empty), 32'd1);
        chk("rst_valid", 32'(sb_if.mem_valid), 32'd0);
        chk("rst_stall", 32'(sb_if.stall), 32'd0);
        chk("rst_waddr", sb_if.mem_waddr, 32'd0);
        chk("rst_wdata", sb_if.mem_wdata, 32'd0);
        @(posedge clk); #1; reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].rdy);
            chk($sformatf("tbl%0d_stall", i), 32'(sb_if.stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_rd", i), sb_if.rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_count", i), 32'(sb_if.count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_empty", i), 32'(sb_if.empty), 32'(tbl[i].e_cnt == 0));
            chk($sformatf("tbl%0d_valid", i), 32'(sb_if.mem_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_waddr", i), sb_if.mem_waddr, tbl[i].e_waddr);
            chk($sformatf("tbl%0d_wdata", i), sb_if.mem_wdata, tbl[i].e_wdata);
            chk($sformatf("tbl%0d_raddr", i), sb_if.mem_raddr, tbl[i].a & 32'hFFFF_FFFC);
        end

        // Same-cycle store/load: old memory value first, forwarded value next cycle.
        rdata_fix = 32'd7;
        step(1, 32'h20, 32'd8, 0);
        chk("samecyc_rd_old", sb_if.rd, 32'd7);
        step(0, 32'h20, 32'd0, 0);
        chk("samecyc_rd_new", sb_if.rd, 32'd8);
        step(0, 32'h0, 32'd0, 1);

        // Async reset with three stores pending.
        step(1, 32'h100, 32'd1, 0);
        step(1, 32'h104, 32'd2, 0);
        step(1, 32'h108, 32'd3, 0);
        step(0, 32'h104, 32'd0, 0);
        chk("pre_rst_count", 32'(sb_if.count), 32'd3);
        chk("pre_rst_valid", 32'(sb_if.mem_valid), 32'd1);
        #2; reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(sb_if.mem_valid), 32'd0);
        chk("async_rst_count", 32'(sb_if.count), 32'd0);
        chk("async_rst_empty", 32'(sb_if.empty), 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        rdata_fix = 32'h77;
        step(0, 32'h104, 32'd0, 0);
        chk("post_rst_rd", sb_if.rd, 32'h77);

        // Wrap-around with mem_ready toggling; resubmit while stalled.
        begin
            int i = 0;
            int cyc = 0;
            int n = 0;
            dut_log.delete();
            while (i < 10 && cyc < 200) begin
                step(1, 32'(4 * i), 32'(i), cyc[0]);
                if (!sb_if.stall) i++;
                cyc++;
            end
            chk("wrap_issued", 32'(i), 32'd10);
            while (!sb_if.empty && n < 100) begin
                step(0, 32'h0, 32'd0, n[0]);
                n++;
            end
            chk("wrap_drained", 32'(sb_if.empty), 32'd1);
            chk("wrap_log_len", 32'(dut_log.size()), 32'd10);
            for (int k = 0; k < dut_log.size() && k < 10; k++) begin
                chk($sformatf("wrap_addr%0d", k), dut_log[k].a, 32'(4 * k));
                chk($sformatf("wrap_data%0d", k), dut_log[k].d, 32'(k));
            end
        end

        // Randomized traffic against a FIFO/log reference model.
        rd_fn = 1'b1;
        dut_log.delete();
        mq.delete();
        mlog.delete();
        for (int c = 0; c < 400; c++) begin
            logic        we_v, rdy_v, st_e, found;
            logic [31:0] a_v, wd_v, rd_e;
            we_v  = ($urandom_range(0, 99) < 60);
            rdy_v = ($urandom_range(0, 99) < 45);
            a_v   = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            wd_v  = $urandom;
            step(we_v, a_v, wd_v, rdy_v);
            st_e  = we_v && (mq.size() == DEPTH) && !rdy_v;
            found = 1'b0;
            rd_e  = mem_fn(a_v & 32'hFFFF_FFFC);
            for (int j = mq.size() - 1; j >= 0; j--)
                if (!found && mq[j].a == (a_v & 32'hFFFF_FFFC)) begin
                    rd_e  = mq[j].d;
                    found = 1'b1;
                end
            chk("rnd_stall", 32'(sb_if.stall), 32'(st_e));
            chk("rnd_rd", sb_if.rd, rd_e);
            chk("rnd_count", 32'(sb_if.count), 32'(mq.size()));
            chk("rnd_valid", 32'(sb_if.mem_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rnd_waddr", sb_if.mem_waddr, mq[0].a);
                chk("rnd_wdata", sb_if.mem_wdata, mq[0].d);
            end
            if (rdy_v && mq.size() != 0) mlog.push_back(mq.pop_front());
            if (we_v && !st_e) mq.push_back('{a_v & 32'hFFFF_FFFC, wd_v});
        end
        @(posedge clk); #1;
        sb_if.we = 1'b0;
        sb_if.mem_ready = 1'b0;
        chk("rnd_log_len", 32'(dut_log.size()), 32'(mlog.size()));
        for (int k = 0; k < dut_log.size() && k < mlog.size(); k++) begin
            chk("rnd_log_addr", dut_log[k].a, mlog[k].a);
            chk("rnd_log_data", dut_log[k].d, mlog[k].d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
